// File: rtl/frame_renderer_if.sv
// rtl/frame_renderer_if.sv - game-state inputs and VGA pixel-write bus of the frame renderer
//
// Signals:
//   start    request a frame render
//   grid     bullet bitmap, bit index = y*SCREEN_W + x
//   user_x   left column of the user ship
//   enemy_x  left column of the enemy
//   x, y     pixel coordinate being written
//   colour   pixel colour
//   plot     pixel write enable
//   busy     frame in progress
//   done     one-cycle pulse after the last pixel
// Modports:
//   master   the renderer (drives the pixel-write side)
//   slave    datapath / adapter side
interface frame_renderer_if #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
);
    logic                         start;
    logic [SCREEN_W*SCREEN_H-1:0] grid;
    logic [7:0]                   user_x;
    logic [7:0]                   enemy_x;
    logic [7:0]                   x;
    logic [6:0]                   y;
    logic [2:0]                   colour;
    logic                         plot;
    logic                         busy;
    logic                         done;

    modport master (
        input  start, grid, user_x, enemy_x,
        output x, y, colour, plot, busy, done
    );

    modport slave (
        output start, grid, user_x, enemy_x,
        input  x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/frame_renderer.sv
// rtl/frame_renderer.sv - renders one 160x120 frame of bullets, ship and enemy per start request
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-low reset
//   bus    master modport of frame_renderer_if (start/grid/user_x/enemy_x in,
//          x/y/colour/plot/busy/done out)
module frame_renderer #(
    parameter int          SCREEN_W   = 160,
    parameter int          SCREEN_H   = 120,
    parameter int          SPRITE_W   = 8,
    parameter int          SPRITE_H   = 8,
    parameter logic [2:0]  COL_BG     = 3'b000,
    parameter logic [2:0]  COL_BULLET = 3'b111,
    parameter logic [2:0]  COL_SHIP   = 3'b010,
    parameter logic [2:0]  COL_ENEMY  = 3'b100
) (
    input  logic                 clk,
    input  logic                 reset,
    frame_renderer_if.master     bus
);
    localparam int GRID_BITS = SCREEN_W * SCREEN_H;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LATCH  = 2'd1,
        S_DRAW   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Raster counters for the pixel being computed this cycle.
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;

    // Frame snapshot; frozen between LATCH and the next LATCH so the image cannot tear.
    logic [GRID_BITS-1:0] grid_q, grid_d;
    logic [7:0]           su_x_q, su_x_d;
    logic [7:0]           se_x_q, se_x_d;

    // Registered pixel-write outputs.
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic        last_pix;
    logic [8:0]  ship_end;
    logic [8:0]  enemy_end;
    logic        ship_hit;
    logic        enemy_hit;
    logic [14:0] grid_idx;
    logic [2:0]  pix_colour;

    assign last_pix = (cx_q == 8'(SCREEN_W - 1)) && (cy_q == 7'(SCREEN_H - 1));

    // Sprite right edges in 9 bits: a sprite near column 255 must not wrap back to 0,
    // and since cx never exceeds SCREEN_W-1, off-screen parts are clipped for free.
    assign ship_end  = {1'b0, su_x_q} + 9'(SPRITE_W);
    assign enemy_end = {1'b0, se_x_q} + 9'(SPRITE_W);

    assign ship_hit  = (cy_q >= 7'(SCREEN_H - SPRITE_H)) &&
                       (cx_q >= su_x_q) && ({1'b0, cx_q} < ship_end);
    assign enemy_hit = (cy_q < 7'(SPRITE_H)) &&
                       (cx_q >= se_x_q) && ({1'b0, cx_q} < enemy_end);

    assign grid_idx = 15'(cy_q) * 15'(SCREEN_W) + 15'(cx_q);

    always_comb begin
        pix_colour = COL_BG;
        if (ship_hit) begin
            pix_colour = COL_SHIP;
        end else if (enemy_hit) begin
            pix_colour = COL_ENEMY;
        end else if (grid_q[grid_idx]) begin
            pix_colour = COL_BULLET;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_LATCH;
            S_LATCH:  state_d = S_DRAW;
            S_DRAW:   if (last_pix) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        cx_d     = cx_q;
        cy_d     = cy_q;
        grid_d   = grid_q;
        su_x_d   = su_x_q;
        se_x_d   = se_x_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = bus.start;
            end
            S_LATCH: begin
                busy_d = 1'b1;
                grid_d = bus.grid;
                su_x_d = bus.user_x;
                se_x_d = bus.enemy_x;
                cx_d   = '0;
                cy_d   = '0;
            end
            S_DRAW: begin
                busy_d   = 1'b1;
                plot_d   = 1'b1;
                x_d      = cx_q;
                y_d      = cy_q;
                colour_d = pix_colour;
                if (cx_q == 8'(SCREEN_W - 1)) begin
                    cx_d = '0;
                    cy_d = cy_q + 7'd1;
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            S_FINISH: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= COL_BG;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Snapshot is only meaningful after a LATCH, so it carries no reset.
    always_ff @(posedge clk) begin
        grid_q <= grid_d;
        su_x_q <= su_x_d;
        se_x_q <= se_x_d;
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_frame_renderer.sv
// tb/tb_frame_renderer.sv - directed self-checking bench for frame_renderer
module tb_frame_renderer;
    localparam int W = 160;
    localparam int H = 120;
    localparam logic [2:0] C_BG   = 3'b000;
    localparam logic [2:0] C_BUL  = 3'b111;
    localparam logic [2:0] C_SHIP = 3'b010;
    localparam logic [2:0] C_EN   = 3'b100;
    localparam logic [2:0] C_NONE = 3'b001;

    logic clk = 1'b0;
    logic reset = 1'b0;

    frame_renderer_if #(.SCREEN_W(W), .SCREEN_H(H)) bus ();

    frame_renderer #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int n_checked  = 0;
    int n_mismatch = 0;

    logic [2:0] fb [0:H-1][0:W-1];
    int plots, done_cnt, done_edge, first_edge, order_err, last_x, last_y;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checked++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int count_col(input int ylo, input int yhi, input int xlo, input int xhi,
                                     input logic [2:0] col);
        int n = 0;
        for (int yy = ylo; yy <= yhi; yy++)
            for (int xx = xlo; xx <= xhi; xx++)
                if (fb[yy][xx] === col) n++;
        return n;
    endfunction

    // start must already be high; edge 0 is the first posedge after the call.
    // mode 1: mid-frame user_x/grid change, ignored start pulse, start held for back-to-back.
    task automatic run_frame(input int mode, input int budget, input int tail);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                fb[yy][xx] = C_NONE;
        plots = 0; done_cnt = 0; done_edge = -1; first_edge = -1;
        order_err = 0; last_x = -1; last_y = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.start = 1'b0;
            if (bus.plot === 1'b1) begin
                if (int'(bus.x) != plots % W || int'(bus.y) != plots / W) order_err++;
                if (int'(bus.x) < W && int'(bus.y) < H) fb[bus.y][bus.x] = bus.colour;
                if (first_edge < 0) first_edge = c - 1;
                last_x = int'(bus.x);
                last_y = int'(bus.y);
                plots++;
                if (mode == 1) begin
                    if (plots == 500) begin
                        bus.user_x = 8'd90;
                        bus.grid[100*W+50] = 1'b1;
                    end
                    if (plots == 1000) bus.start = 1'b1;
                    else if (plots == 1001) bus.start = 1'b0;
                    if (plots == 19100) bus.start = 1'b1;
                end
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) done_edge = c - 1;
            end
            if (done_edge >= 0 && (c - 1) >= done_edge + tail) break;
        end
    endtask

    int found, dcnt, bcnt;

    initial begin
        bus.start   = 1'b1;
        bus.grid    = '0;
        bus.user_x  = 8'd0;
        bus.enemy_x = 8'd76;
        reset       = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_val("rst_plot",   bus.plot,   0);
            check_val("rst_busy",   bus.busy,   0);
            check_val("rst_done",   bus.done,   0);
            check_val("rst_x",      bus.x,      0);
            check_val("rst_y",      bus.y,      0);
            check_val("rst_colour", bus.colour, C_BG);
        end
        bus.start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("idle_busy", bus.busy, 0);

        // Frame A: ship at 0, enemy at 76, two bullets (one under the ship)
        bus.grid = '0;
        bus.grid[60*W+30] = 1'b1;
        bus.grid[119*W+3] = 1'b1;
        bus.user_x  = 8'd0;
        bus.enemy_x = 8'd76;
        bus.start   = 1'b1;
        run_frame(0, 19400, 4);
        check_val("A_plots",      plots,      19200);
        check_val("A_done_cnt",   done_cnt,   1);
        check_val("A_done_edge",  done_edge,  19202);
        check_val("A_first_edge", first_edge, 2);
        check_val("A_order_err",  order_err,  0);
        check_val("A_last_x",     last_x,     159);
        check_val("A_last_y",     last_y,     119);
        check_val("A_px_0_112",   fb[112][0],  C_SHIP);
        check_val("A_px_80_0",    fb[0][80],   C_EN);
        check_val("A_px_100_50",  fb[50][100], C_BG);
        check_val("A_px_30_60",   fb[60][30],  C_BUL);
        check_val("A_px_3_119",   fb[119][3],  C_SHIP);
        check_val("A_px_7_119",   fb[119][7],  C_SHIP);
        check_val("A_px_8_119",   fb[119][8],  C_BG);
        check_val("A_px_0_111",   fb[111][0],  C_BG);
        check_val("A_px_75_0",    fb[0][75],   C_BG);
        check_val("A_px_83_0",    fb[0][83],   C_EN);
        check_val("A_px_84_0",    fb[0][84],   C_BG);
        check_val("A_px_80_8",    fb[8][80],   C_BG);
        check_val("A_ship_cnt",   count_col(112, 119, 0, W-1, C_SHIP), 64);
        check_val("A_enemy_cnt",  count_col(0, 7, 0, W-1, C_EN),      64);
        check_val("A_bullet_cnt", count_col(0, H-1, 0, W-1, C_BUL),    1);

        // Frame B: snapshot isolation, start ignored while busy, held start
        bus.grid    = '0;
        bus.user_x  = 8'd10;
        bus.enemy_x = 8'd200;
        bus.start   = 1'b1;
        run_frame(1, 19400, 0);
        check_val("B_plots",      plots,     19200);
        check_val("B_done_cnt",   done_cnt,  1);
        check_val("B_done_edge",  done_edge, 19202);
        check_val("B_order_err",  order_err, 0);
        check_val("B_ship_cnt",   count_col(112, 119, 0, W-1, C_SHIP), 64);
        check_val("B_ship_cols",  count_col(112, 119, 10, 17, C_SHIP), 64);
        check_val("B_px_90_112",  fb[112][90], C_BG);
        check_val("B_px_50_100",  fb[100][50], C_BG);
        check_val("B_enemy_cnt",  count_col(0, 7, 0, W-1, C_EN), 0);
        check_val("B_gap_busy",   bus.busy, 0);
        @(posedge clk); #1;
        check_val("B2B_busy",     bus.busy, 1);
        check_val("B2B_plot",     bus.plot, 0);
        check_val("B2B_done",     bus.done, 0);
        bus.start = 1'b0;

        // Frame C: reset asserted at pixel (40,20)
        found = 0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            if (bus.plot === 1'b1 && bus.x == 8'd40 && bus.y == 7'd20) begin
                found = 1;
                break;
            end
        end
        check_val("C_reach_40_20", found, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("C_abort_plot", bus.plot, 0);
        check_val("C_abort_busy", bus.busy, 0);
        check_val("C_abort_x",    bus.x,    0);
        reset = 1'b1;
        dcnt = 0;
        bcnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dcnt++;
            if (bus.busy === 1'b1) bcnt++;
        end
        check_val("C_no_done", dcnt, 0);
        check_val("C_no_busy", bcnt, 0);

        // Frame D: ship partly off the right edge
        bus.grid    = '0;
        bus.user_x  = 8'd156;
        bus.enemy_x = 8'd76;
        bus.start   = 1'b1;
        run_frame(0, 19400, 2);
        check_val("D_plots",      plots,     19200);
        check_val("D_done_cnt",   done_cnt,  1);
        check_val("D_order_err",  order_err, 0);
        check_val("D_ship_cols",  count_col(112, 119, 156, 159, C_SHIP), 32);
        check_val("D_ship_cnt",   count_col(112, 119, 0, W-1, C_SHIP),   32);
        check_val("D_nowrap",     count_col(112, 112, 0, 3, C_BG),       4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_mismatch);
        $finish;
    end
endmodule
